// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle controller and the datapath decoders.
package mc_controller_pkg;

  // Controller states; codes 13..15 are unused and recover to StFetch.
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StOriEx   = 4'd10,
    StImmWb   = 4'd11,
    StJEx     = 4'd12
  } state_e;

  // Instruction opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select, shared with the ALU decoder.
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_OR   = 2'b11;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // Next-PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Decoded datapath controls produced by the output decoder.
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic       pcen;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // True for the seven opcodes the controller implements.
  function automatic logic op_is_legal(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_ORI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath signal bundle.
interface mc_controller_if;
  import mc_controller_pkg::*;

  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic       pcen;
  logic       illegal_op;
  logic       retire;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;

  // Controller side.
  modport master (
    input  op, zero, mem_ready,
    output iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen,
           illegal_op, retire, alusrcb, pcsrc, aluop
  );

  // Datapath side.
  modport slave (
    output op, zero, mem_ready,
    input  iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen,
           illegal_op, retire, alusrcb, pcsrc, aluop
  );

endinterface

// File: rtl/mc_outdec.sv
// Moore output decode: state (plus mem_ready/zero qualifiers) -> datapath controls.
module mc_outdec
  import mc_controller_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  logic pc_write;

  // Per-state control decode; anything not named for a state stays 0.
  always_comb begin
    ctrl         = '0;
    ctrl.alusrcb = SRCB_REG;
    ctrl.pcsrc   = PCSRC_ALU;
    ctrl.aluop   = ALUOP_ADD;
    pc_write     = 1'b0;
    case (state)
      StFetch: begin
        ctrl.alusrcb = SRCB_FOUR;
        // IR load and PC+4 only commit once the fetch read has completed.
        ctrl.irwrite = mem_ready;
        pc_write     = mem_ready;
      end
      StDecode: begin
        ctrl.alusrcb = SRCB_BRANCH;
      end
      StMemAdr: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      StMemRd: begin
        ctrl.iord = 1'b1;
      end
      StMemWr: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      StMemWb: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      StRtypeEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNC;
      end
      StRtypeWb: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      StBeqEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_BRANCH;
      end
      StAddiEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      StOriEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_OR;
      end
      StImmWb: begin
        ctrl.regwrite = 1'b1;
      end
      StJEx: begin
        ctrl.pcsrc = PCSRC_JUMP;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
    ctrl.pcen = pc_write | ((state == StBeqEx) & zero);
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle processor main controller: state register, sequencing and status flags.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  mc_controller_if.master   bus
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   retire_q, retire_d;
  logic   mem_ready_gated;
  ctrl_t  ctrl;

  // Keep fetch-side IR/PC writes quiet while reset is held, even with mem_ready high.
  assign mem_ready_gated = bus.mem_ready & reset_n;

  // State and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retire_q  <= retire_d;
    end
  end

  // Instruction sequencing, sticky illegal flag and retire detection.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StFetch: begin
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StRtypeEx;
          OP_BEQ:       state_d = StBeqEx;
          OP_ADDI:      state_d = StAddiEx;
          OP_ORI:       state_d = StOriEx;
          OP_J:         state_d = StJEx;
          default:      state_d = StFetch;
        endcase
        if (!op_is_legal(bus.op)) illegal_d = 1'b1;
      end
      StMemAdr:  state_d = (bus.op == OP_SW) ? StMemWr : StMemRd;
      StMemRd: begin
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWr: begin
        if (bus.mem_ready) state_d = StFetch;
      end
      StMemWb:   state_d = StFetch;
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StBeqEx:   state_d = StFetch;
      StAddiEx:  state_d = StImmWb;
      StOriEx:   state_d = StImmWb;
      StImmWb:   state_d = StFetch;
      StJEx:     state_d = StFetch;
      default:   state_d = StFetch;
    endcase
    // DECODE -> FETCH only happens for a rejected opcode, which does not retire.
    retire_d = (state_q != StFetch) && (state_q != StDecode) && (state_d == StFetch);
  end

  mc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready_gated),
    .zero      (bus.zero),
    .ctrl      (ctrl)
  );

  // Drive the bus from the decoded controls and status registers.
  always_comb begin
    bus.iord       = ctrl.iord;
    bus.irwrite    = ctrl.irwrite;
    bus.memwrite   = ctrl.memwrite;
    bus.regwrite   = ctrl.regwrite;
    bus.regdst     = ctrl.regdst;
    bus.memtoreg   = ctrl.memtoreg;
    bus.alusrca    = ctrl.alusrca;
    bus.pcen       = ctrl.pcen;
    bus.alusrcb    = ctrl.alusrcb;
    bus.pcsrc      = ctrl.pcsrc;
    bus.aluop      = ctrl.aluop;
    bus.illegal_op = illegal_q;
    bus.retire     = retire_q;
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench: instruction-level reference model pushes per-cycle expectations,
// a negedge monitor pops and compares them with the controller outputs.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mc_controller_if bus ();

  mc_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen;
    logic       illegal_op, retire;
    logic [1:0] alusrcb, pcsrc, aluop;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model status.
  bit ill_m = 1'b0;
  bit ret_m = 1'b0;

  // Micro-program of the steps that follow DECODE for one instruction.
  vec_t  prog_v[4];
  bit    prog_wait[4];
  bit    prog_beq[4];
  string prog_tag[4];
  int    prog_n;

  function automatic vec_t mk(logic a, logic [1:0] b, logic [1:0] alu, logic [1:0] pc,
                              logic iord, logic mw, logic rw, logic rd, logic m2r,
                              logic pcen);
    vec_t e;
    e          = '0;
    e.alusrca  = a;
    e.alusrcb  = b;
    e.aluop    = alu;
    e.pcsrc    = pc;
    e.iord     = iord;
    e.memwrite = mw;
    e.regwrite = rw;
    e.regdst   = rd;
    e.memtoreg = m2r;
    e.pcen     = pcen;
    return e;
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101,
                      6'b000010};
  endfunction

  function automatic void add_step(vec_t v, bit w, bit b, string t);
    prog_v[prog_n]    = v;
    prog_wait[prog_n] = w;
    prog_beq[prog_n]  = b;
    prog_tag[prog_n]  = t;
    prog_n++;
  endfunction

  function automatic void load_prog(logic [5:0] op);
    vec_t adr;
    vec_t immwb;
    adr    = mk(1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    immwb  = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
    prog_n = 0;
    case (op)
      6'b100011: begin
        add_step(adr, 0, 0, "lw_memadr");
        add_step(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0), 1, 0, "lw_memrd");
        add_step(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0), 0, 0, "lw_memwb");
      end
      6'b101011: begin
        add_step(adr, 0, 0, "sw_memadr");
        add_step(mk(0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0), 1, 0, "sw_memwr");
      end
      6'b000000: begin
        add_step(mk(1, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0), 0, 0, "r_ex");
        add_step(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0), 0, 0, "r_wb");
      end
      6'b000100: add_step(mk(1, 2'b00, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0), 0, 1, "beq_ex");
      6'b001000: begin
        add_step(mk(1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), 0, 0, "addi_ex");
        add_step(immwb, 0, 0, "addi_wb");
      end
      6'b001101: begin
        add_step(mk(1, 2'b10, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0), 0, 0, "ori_ex");
        add_step(immwb, 0, 0, "ori_wb");
      end
      6'b000010: add_step(mk(0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0, 1), 0, 0, "j_ex");
      default: ;
    endcase
  endfunction

  // One clock of stimulus: record what the DUT must show this cycle, then advance.
  task automatic tick(input vec_t e, input string tag);
    e.illegal_op = ill_m;
    e.retire     = ret_m;
    sb.push_back('{v: e, tag: tag});
    ret_m = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycles(input int n);
    vec_t e;
    reset_n = 1'b0;
    ill_m   = 1'b0;
    ret_m   = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      e = mk(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      tick(e, "reset");
    end
    reset_n = 1'b1;
  endtask

  // Run one instruction. zmode: 0/1 fixed zero, 2 random. low: mem_ready-low cycles
  // in the memory step (directed mode). abort: assert reset once those cycles elapse.
  task automatic run_instr(input logic [5:0] op, input bit rnd, input int zmode,
                           input int low_cycles, input bit abort);
    vec_t e;
    bit   done;
    int   low;
    low    = low_cycles;
    bus.op = op;
    done   = 1'b0;
    while (!done) begin
      bus.mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.zero      = 1'($urandom_range(0, 1));
      e         = mk(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      e.irwrite = bus.mem_ready;
      e.pcen    = bus.mem_ready;
      done      = bus.mem_ready;
      tick(e, "fetch");
    end
    bus.mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.zero      = 1'($urandom_range(0, 1));
    tick(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "decode");
    if (!legal(op)) begin
      ill_m = 1'b1;
      return;
    end
    load_prog(op);
    for (int s = 0; s < prog_n; s++) begin
      if (prog_wait[s]) begin
        done = 1'b0;
        while (!done) begin
          if (abort && low == 0) begin
            bus.mem_ready = 1'b0;
            reset_cycles(2);
            return;
          end
          if (rnd && !abort) bus.mem_ready = ($urandom_range(0, 2) != 0);
          else               bus.mem_ready = (low == 0);
          if (low > 0) low--;
          bus.zero = 1'($urandom_range(0, 1));
          done     = bus.mem_ready;
          tick(prog_v[s], prog_tag[s]);
        end
      end else begin
        bus.mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.zero      = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        e = prog_v[s];
        if (prog_beq[s]) e.pcen = bus.zero;
        tick(e, prog_tag[s]);
      end
    end
    ret_m = 1'b1;
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      vec_t a;
      x            = sb.pop_front();
      a.iord       = bus.iord;
      a.irwrite    = bus.irwrite;
      a.memwrite   = bus.memwrite;
      a.regwrite   = bus.regwrite;
      a.regdst     = bus.regdst;
      a.memtoreg   = bus.memtoreg;
      a.alusrca    = bus.alusrca;
      a.pcen       = bus.pcen;
      a.illegal_op = bus.illegal_op;
      a.retire     = bus.retire;
      a.alusrcb    = bus.alusrcb;
      a.pcsrc      = bus.pcsrc;
      a.aluop      = bus.aluop;
      compared++;
      if (a !== x.v) begin
        mismatched++;
        $display("FAIL %s @%0t: got %b required %b", x.tag, $time, a, x.v);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops[7];
    logic [5:0] op;
    int         k;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b001101; ops[6] = 6'b000010;
    bus.op        = 6'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_cycles(2);

    // Directed scenarios.
    run_instr(6'b100011, 0, 0, 0, 0);  // lw, mem_ready always high
    run_instr(6'b101011, 0, 0, 3, 0);  // sw, three wait cycles
    run_instr(6'b000100, 0, 1, 0, 0);  // beq taken
    run_instr(6'b000100, 0, 0, 0, 0);  // beq not taken
    run_instr(6'b001101, 0, 0, 0, 0);  // ori
    run_instr(6'b000000, 0, 0, 0, 0);  // R-type
    run_instr(6'b001000, 0, 0, 0, 0);  // addi
    run_instr(6'b000010, 0, 0, 0, 0);  // j
    run_instr(6'b111111, 0, 0, 0, 0);  // illegal
    run_instr(6'b100011, 0, 0, 0, 0);  // flag stays set
    run_instr(6'b101011, 0, 0, 2, 1);  // reset mid-write
    run_instr(6'b100011, 0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 8);
      if (k < 7) begin
        op = ops[k];
      end else begin
        op = 6'($urandom_range(0, 63));
        while (legal(op)) op = 6'($urandom_range(0, 63));
      end
      run_instr(op, 1, 2, 0, ($urandom_range(0, 9) == 0));
    end
    tick(mk(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "final_fetch_idle");

    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
